// File: rtl/fifo_reader_pkg.sv
// Shared types and sizing for the FIFO stream reader.
// The frame length grows by one parity bit when FIFO_READER_PARITY_EN is defined.
package fifo_reader_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_CAPT  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  function automatic int frame_len(input int w);
`ifdef FIFO_READER_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

  localparam int FRAME_LEN = frame_len(DEF_WIDTH);

`ifdef FIFO_READER_PARITY_EN
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction
`endif

endpackage

// File: rtl/fifo_stream_reader_piso.sv
// Loadable parallel-in serial-out register, MSB first, with bit index and last-bit flag.
// Exposes next-cycle MSB / first-bit values so the top can register its outputs.
module piso_shifter #(
  parameter int LEN   = 4,
  parameter int IDX_W = $clog2(LEN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [LEN-1:0] data_i,
  input  logic           shift_i,
  output logic           last_o,
  output logic           nxt_msb_o,
  output logic           nxt_first_o
);

  logic [LEN-1:0]   sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    if (load_i) begin
      sh_d  = data_i;
      idx_d = '0;
    end else if (shift_i) begin
      sh_d  = {sh_q[LEN-2:0], 1'b0};
      idx_d = idx_q + IDX_W'(1);
    end else begin
      sh_d  = sh_q;
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

  assign last_o      = (idx_q == IDX_W'(LEN - 1));
  assign nxt_msb_o   = sh_d[LEN-1];
  assign nxt_first_o = (idx_d == '0);

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a latency-1 synchronous FIFO and serialises each word MSB-first under tx_ready.
// Optional even-parity trailer bit: FIFO_READER_PARITY_EN.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic             fifo_wr,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  input  logic             tx_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int FLEN = frame_len(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic             sout_q, sout_d;
  logic             sval_q, sval_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;

  logic            accepted_s;
  logic            load_s;
  logic            shift_s;
  logic            last_s;
  logic            nxt_msb_s;
  logic            nxt_first_s;
  logic [FLEN-1:0] load_word_s;

`ifdef FIFO_READER_PARITY_EN
  assign load_word_s = {fifo_data, even_parity(64'(fifo_data))};
`else
  assign load_word_s = fifo_data;
`endif

  // The FIFO favours a concurrent write, so a pop only lands when no write is accepted.
  assign accepted_s = rd_q & ~fifo_empty & ~(fifo_wr & ~fifo_full);
  assign load_s     = (state_q == ST_CAPT);
  assign shift_s    = (state_q == ST_SHIFT) & tx_ready;

  piso_shifter #(.LEN(FLEN)) u_piso (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_s),
    .data_i      (load_word_s),
    .shift_i     (shift_s),
    .last_o      (last_s),
    .nxt_msb_o   (nxt_msb_s),
    .nxt_first_o (nxt_first_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_POP;
        else             state_d = ST_IDLE;
      end
      ST_POP: begin
        if (accepted_s)      state_d = ST_CAPT;
        else if (fifo_empty) state_d = ST_IDLE;
        else                 state_d = ST_POP;
      end
      ST_CAPT: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (shift_s && last_s) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = fifo_empty ? ST_IDLE : ST_POP;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from next-state values so they align with the state they describe.
    rd_d   = (state_d == ST_POP);
    sval_d = (state_d == ST_SHIFT);
    sout_d = sval_d & nxt_msb_s;
    fs_d   = sval_d & nxt_first_s;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      sout_q  <= 1'b0;
      sval_q  <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      sout_q  <= sout_d;
      sval_q  <= sval_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
    end
  end

  assign fifo_rd     = rd_q;
  assign ser_out     = sout_q;
  assign ser_valid   = sval_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign word_count  = cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small behavioural latency-1 FIFO.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_wr;
  logic [3:0] fifo_data;
  logic       fifo_rd;
  logic       tx_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       frame_start;
  logic       busy;
  logic [7:0] word_count;

  fifo_stream_reader dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_wr(fifo_wr), .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx_ready(tx_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
    .busy(busy), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  q[$];
  logic [3:0]  wr_data;
  logic [31:0] stream;
  int          nbits, rd_count, fs_count;
  logic [15:0] rd_log, val_log, ser_log, fs_log, busy_log;
  logic        prev_stall, prev_val, prev_ser, prev_fs;
  logic        seen_v;
  int          cur_gap, max_gap;
  logic [7:0]  exp_count;

  task automatic clear_logs();
    stream = '0; nbits = 0; rd_count = 0; fs_count = 0;
    rd_log = '0; val_log = '0; ser_log = '0; fs_log = '0; busy_log = '0;
    prev_stall = 1'b0; seen_v = 1'b0; cur_gap = 0; max_gap = 0;
  endtask

  // One clock cycle: observe outputs, run the FIFO model across the edge.
  task automatic cyc();
    logic acc, wacc;
    n_cmp++;
    if (!ser_valid && ser_out !== 1'b0) begin
      n_err++; $display("FAIL ser_out_idle: got %b want 0", ser_out);
    end
    if (prev_stall) begin
      n_cmp++;
      if ({ser_valid, ser_out, frame_start} !== {prev_val, prev_ser, prev_fs}) begin
        n_err++;
        $display("FAIL stall_hold: got %b%b%b want %b%b%b", ser_valid, ser_out, frame_start,
                 prev_val, prev_ser, prev_fs);
      end
    end
    prev_stall = ser_valid & ~tx_ready;
    prev_val = ser_valid; prev_ser = ser_out; prev_fs = frame_start;
    if (ser_valid && tx_ready) begin stream = {stream[30:0], ser_out}; nbits++; end
    if (fifo_rd) rd_count++;
    if (frame_start) fs_count++;
    if (ser_valid) begin
      if (seen_v && cur_gap > 0) max_gap = cur_gap;
      cur_gap = 0; seen_v = 1'b1;
    end else if (seen_v) begin
      cur_gap++;
    end
    rd_log = {rd_log[14:0], fifo_rd}; val_log = {val_log[14:0], ser_valid};
    ser_log = {ser_log[14:0], ser_out}; fs_log = {fs_log[14:0], frame_start};
    busy_log = {busy_log[14:0], busy};
    acc  = fifo_rd & ~fifo_empty & ~(fifo_wr & ~fifo_full);
    wacc = fifo_wr & ~fifo_full;
    @(posedge clk); #1;
    if (acc) fifo_data = q.pop_front();
    if (wacc) q.push_back(wr_data);
    fifo_empty = (q.size() == 0);
  endtask

  task automatic test_reset();
    rst = 1'b0; fifo_empty = 1'b1; fifo_full = 1'b0; fifo_wr = 1'b0;
    fifo_data = 4'h0; tx_ready = 1'b1; wr_data = 4'h0;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if ({fifo_rd, ser_out, ser_valid, frame_start, busy} !== 5'b00000) begin
      n_err++; $display("FAIL reset_outputs: got %b want 00000",
                        {fifo_rd, ser_out, ser_valid, frame_start, busy});
    end
    n_cmp++;
    if (word_count !== 8'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", word_count);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL idle_empty: busy %b want 0", busy); end
    exp_count = 8'd0;
    clear_logs();
  endtask

  task automatic test_single_word();
    clear_logs();
    q.push_back(4'hA); fifo_empty = 1'b0; tx_ready = 1'b1;
    repeat (8) cyc();
    exp_count = exp_count + 8'd1;
    n_cmp++; if (rd_log[7:0] !== 8'b0100_0000) begin n_err++; $display("FAIL sw_rd: got %b want 01000000", rd_log[7:0]); end
    n_cmp++; if (val_log[7:0] !== 8'b0001_1110) begin n_err++; $display("FAIL sw_valid: got %b want 00011110", val_log[7:0]); end
    n_cmp++; if (ser_log[7:0] !== 8'b0001_0100) begin n_err++; $display("FAIL sw_ser: got %b want 00010100", ser_log[7:0]); end
    n_cmp++; if (fs_log[7:0] !== 8'b0001_0000) begin n_err++; $display("FAIL sw_fs: got %b want 00010000", fs_log[7:0]); end
    n_cmp++; if (busy_log[7:0] !== 8'b0111_1110) begin n_err++; $display("FAIL sw_busy: got %b want 01111110", busy_log[7:0]); end
    n_cmp++; if (word_count !== exp_count) begin n_err++; $display("FAIL sw_count: got %0d want %0d", word_count, exp_count); end
  endtask

  task automatic test_pop_collision();
    clear_logs();
    q.push_back(4'h5); fifo_empty = 1'b0; tx_ready = 1'b1;
    cyc();
    fifo_wr = 1'b1; wr_data = 4'h9;
    cyc();
    fifo_wr = 1'b0;
    repeat (2) cyc();
    n_cmp++; if (rd_log[3:0] !== 4'b0110) begin n_err++; $display("FAIL col_rd_retry: got %b want 0110", rd_log[3:0]); end
    repeat (16) cyc();
    exp_count = exp_count + 8'd2;
    n_cmp++; if (stream[7:0] !== 8'b0101_1001 || nbits != 8) begin
      n_err++; $display("FAIL col_stream: got %b (%0d bits) want 01011001 (8 bits)", stream[7:0], nbits); end
    n_cmp++; if (rd_count != 3) begin n_err++; $display("FAIL col_rd_count: got %0d want 3", rd_count); end
    n_cmp++; if (fs_count != 2) begin n_err++; $display("FAIL col_frames: got %0d want 2", fs_count); end
    n_cmp++; if (word_count !== exp_count) begin n_err++; $display("FAIL col_count: got %0d want %0d", word_count, exp_count); end
  endtask

  task automatic test_back_to_back_stall();
    clear_logs();
    q.push_back(4'h3); q.push_back(4'hC); fifo_empty = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tx_ready = ((i % 4) == 0) || ((i % 4) == 3);
      cyc();
    end
    tx_ready = 1'b1;
    exp_count = exp_count + 8'd2;
    n_cmp++; if (stream[7:0] !== 8'b0011_1100 || nbits != 8) begin
      n_err++; $display("FAIL b2b_stream: got %b (%0d bits) want 00111100 (8 bits)", stream[7:0], nbits); end
    n_cmp++; if (max_gap != 2) begin n_err++; $display("FAIL b2b_gap: got %0d want 2", max_gap); end
    n_cmp++; if (word_count !== exp_count) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", word_count, exp_count); end
  endtask

  task automatic test_empty_during_pop();
    clear_logs();
    q.push_back(4'h6); fifo_empty = 1'b0; tx_ready = 1'b1;
    cyc();
    q.delete(); fifo_empty = 1'b1;
    repeat (7) cyc();
    n_cmp++; if (busy_log[7:0] !== 8'b0100_0000) begin n_err++; $display("FAIL ep_busy: got %b want 01000000", busy_log[7:0]); end
    n_cmp++; if (rd_count != 1) begin n_err++; $display("FAIL ep_rd_count: got %0d want 1", rd_count); end
    n_cmp++; if (nbits != 0 || fs_count != 0) begin n_err++; $display("FAIL ep_no_frame: got %0d bits want 0", nbits); end
    n_cmp++; if (word_count !== exp_count) begin n_err++; $display("FAIL ep_count: got %0d want %0d", word_count, exp_count); end
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    q.push_back(4'hF); fifo_empty = 1'b0; tx_ready = 1'b1;
    repeat (5) cyc();
    n_cmp++; if (ser_valid !== 1'b1) begin n_err++; $display("FAIL rm_third_bit: valid %b want 1", ser_valid); end
    rst = 1'b0;
    cyc();
    n_cmp++;
    if ({fifo_rd, ser_out, ser_valid, frame_start, busy} !== 5'b00000 || word_count !== 8'd0) begin
      n_err++; $display("FAIL rm_outputs: got %b count %0d want 00000 count 0",
                        {fifo_rd, ser_out, ser_valid, frame_start, busy}, word_count);
    end
    rst = 1'b1; exp_count = 8'd0;
    repeat (5) cyc();
    n_cmp++; if (busy_log[4:0] !== 5'b00000) begin n_err++; $display("FAIL rm_idle: got %b want 00000", busy_log[4:0]); end
    n_cmp++; if (word_count !== exp_count) begin n_err++; $display("FAIL rm_count: got %0d want 0", word_count); end
  endtask

`ifdef FIFO_READER_PARITY_EN
  task automatic test_parity();
    clear_logs();
    q.push_back(4'h7); q.push_back(4'h5); fifo_empty = 1'b0; tx_ready = 1'b1;
    repeat (20) cyc();
    exp_count = exp_count + 8'd2;
    n_cmp++; if (stream[9:0] !== 10'b01111_01010 || nbits != 10) begin
      n_err++; $display("FAIL par_stream: got %b (%0d bits) want 0111101010 (10 bits)", stream[9:0], nbits); end
    n_cmp++; if (fs_count != 2) begin n_err++; $display("FAIL par_frames: got %0d want 2", fs_count); end
    n_cmp++; if (word_count !== exp_count) begin n_err++; $display("FAIL par_count: got %0d want %0d", word_count, exp_count); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FIFO_READER_PARITY_EN
    test_parity();
`else
    test_single_word();
    test_pop_collision();
    test_back_to_back_stall();
`endif
    test_empty_during_pop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
